mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the multi-cycle MIPS core.
- Executes mult, multu, div and divu on a radix-2 iterative datapath, and owns the HI and LO registers.
- The main controller pulses start, stalls on busy, and reads hi/lo for mfhi/mflo.
- Also accepts mthi/mtlo writes.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 5: iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand: multiplicand or dividend.
- b  in  WIDTH  rt operand: multiplier or divisor.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in progress; the main controller stalls on it.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_zero  out  1  sticky flag: last divide had b==0; cleared by the next start.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter=0. Reset mid-operation aborts immediately with no partial HI/LO update.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 (edge T0):
  - latch op;
  - latch |a| and |b| for signed ops (raw values for unsigned);
  - latch sign flags;
  - clear counter and div_zero;
  - go to CALC. busy=1 from T0.
- CALC: one iteration per clock, counter 0..WIDTH-1 (edges T1..T32 for WIDTH=32). At counter==WIDTH-1 go to FIX.
  - Multiply: 2*WIDTH-bit shift-add accumulator.
  - Divide: restoring division, with a WIDTH+1-bit partial remainder.
- FIX (edge T33):
  - Apply sign correction and write hi/lo.
  - mult: negate the 2*WIDTH product if sign(a)^sign(b).
  - div: negate the quotient if sign(a)^sign(b); the remainder takes the sign of a.
  - Go to DONE. busy drops to 0 at this edge.
- DONE: done=1 for exactly one cycle, then IDLE. Total: start edge to done-high takes WIDTH+2 edges.
- Unsigned ops skip negation; FIX still costs one cycle, so latency is fixed.
- Divide by zero:
  - set div_zero=1; hi=a (raw dividend); lo=all ones;
  - latency is unchanged unless the optional feature is enabled.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, div): lo=0x80000000, hi=0, div_zero=0.
- start while busy or in DONE: ignored, no queuing.
- mthi/mtlo:
  - honoured only in IDLE or DONE, written at the clock edge;
  - ignored while busy.
  - If start and mthi/mtlo arrive in the same IDLE cycle, start wins and the move is dropped.
  - mthi and mtlo in the same cycle both write wdata.
- hi/lo hold their last value at all times except the FIX edge and mthi/mtlo writes.
- Width rules: the accumulator is 2*WIDTH bits. Negation is two's complement, modulo 2^WIDTH per register; for mult it is modulo 2^(2*WIDTH).

Optional Feature:
- Macro: MDU_DIVZERO_FAST_EN.
- Defined: a div/divu with b==0 goes from IDLE directly to FIX, skipping CALC. done is high 2 edges after start instead of WIDTH+2. Results are identical (hi=a, lo=all ones, div_zero=1).
- Undefined: all ops take the full WIDTH+2 latency. This is the default.

Decomposition:
- Package mdu_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding IDLE/CALC/FIX/DONE;
  - the default WIDTH.
- One natural sub-module, mdu_step: combinational single iteration. It takes accumulator, operand and op class, and returns the next accumulator (shift-add or trial-subtract-restore). The FSM, counter, sign fix and HI/LO registers stay in mdu_seq.

Test Plan:
- mult a=7, b=0xFFFFFFFD -> done at T0+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T0..T32.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=100, b=0 -> hi=0x64, lo=0xFFFFFFFF, div_zero=1. Timing: done at T0+34 without the macro, at T0+2 with MDU_DIVZERO_FAST_EN.
- mtlo wdata=0x1234 in IDLE -> lo=0x1234 next cycle. Second start and mthi pulsed mid-CALC -> both ignored, result unaffected.
- rst asserted at T0+10 of a mult -> next edge: busy=0, done=0, hi=lo=0. A fresh multu 3*5 then gives lo=15, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation and
// state encodings, the default operand width, and small op decoders.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  // Divide ops have op[1] set; signed ops have op[0] clear.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial product high, multiplier}; add-if-lsb then shift right.
// Divide:   acc = {partial remainder, dividend/quotient}; shift left,
//           trial-subtract the divisor, keep or restore.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Single combinational iteration; the remainder always stays below the
  // divisor, so WIDTH bits hold it and WIDTH+1 bits hold the shifted trial.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    shifted = acc_in[2*WIDTH-1:WIDTH-1];
    trial   = shifted - {1'b0, operand};
    acc_out = acc_in;
    if (is_div) begin
      if (trial[WIDTH]) begin
        acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Operates on magnitudes through an iterative datapath and fixes signs at
// the end. Optional macro MDU_DIVZERO_FAST_EN: divide by zero jumps
// straight from IDLE to FIX instead of running the full iteration count.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_e         state_reg;
  logic [1:0]         op_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand_reg;
  logic [WIDTH-1:0]   raw_a_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               div_zero_reg;

  logic               in_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dz;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_reg),
    .operand (operand_reg),
    .is_div  (op_is_div(op_reg)),
    .acc_out (acc_next)
  );

  // Operand magnitudes for the incoming request (raw values for unsigned ops).
  always_comb begin
    in_signed = op_is_signed(op);
    abs_a     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Sign correction and divide-by-zero override applied on the FIX edge.
  always_comb begin
    prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    fix_dz   = 1'b0;
    if (op_is_div(op_reg)) begin
      if (operand_reg == '0) begin
        fix_hi = raw_a_reg;
        fix_lo = '1;
        fix_dz = 1'b1;
      end else begin
        fix_lo = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[WIDTH-1:0] + 1'b1)
                                           : acc_reg[WIDTH-1:0];
        fix_hi = sign_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                            : acc_reg[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Sequencer FSM with registered outputs and the HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_MULT;
      acc_reg      <= '0;
      operand_reg  <= '0;
      raw_a_reg    <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg       <= op;
            raw_a_reg    <= a;
            sign_a_reg   <= in_signed & a[WIDTH-1];
            sign_b_reg   <= in_signed & b[WIDTH-1];
            acc_reg      <= {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
            operand_reg  <= op_is_div(op) ? abs_b : abs_a;
            cnt_reg      <= '0;
            div_zero_reg <= 1'b0;
            busy_reg     <= 1'b1;
`ifdef MDU_DIVZERO_FAST_EN
            state_reg    <= (op_is_div(op) && (b == '0)) ? FIX : CALC;
`else
            state_reg    <= CALC;
`endif
          end else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) state_reg <= FIX;
        end
        FIX: begin
          hi_reg       <= fix_hi;
          lo_reg       <= fix_lo;
          div_zero_reg <= fix_dz;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b1;
          state_reg    <= DONE;
        end
        DONE: begin
          if (mthi) hi_reg <= wdata;
          if (mtlo) lo_reg <= wdata;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes hand-computed results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;
`ifdef MDU_DIVZERO_FAST_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           t0;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, required no done", hi, lo);
      end else begin
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz || (cyc - e.t0) != e.lat) begin
          bad++;
          $display("FAIL %s: got hi=%h lo=%h dz=%b lat=%0d, required hi=%h lo=%h dz=%b lat=%0d",
                   e.name, hi, lo, div_zero, cyc - e.t0, e.hi, e.lo, e.dz, e.lat);
        end else begin
          $display("ok %s: hi=%h lo=%h dz=%b lat=%0d", e.name, hi, lo, div_zero, cyc - e.t0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end else begin
      $display("ok %s: %h", name, got);
    end
  endtask

  // Issue one operation, push its expected result and follow busy until done.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int elat,
                        input bit with_move, input bit disturb);
    exp_t e;
    int   k;
    bit   busy_ok;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    mthi = with_move; mtlo = with_move; wdata = 32'h0000_DEAD;
    e.hi = eh; e.lo = el; e.dz = edz; e.lat = elat; e.t0 = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = ~o; a = ~av; b = ~bv;
    busy_ok = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      if (busy !== ((cyc - e.t0) < elat)) busy_ok = 1'b0;
      if (disturb && k == 5) begin
        start = 1'b1; op = OP_MULT; a = 32'd1; b = 32'd1;
        mthi = 1'b1; wdata = 32'h0000_AAAA;
      end
      if (k == 6) begin
        start = 1'b0; mthi = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; mthi = 1'b0;
    if (k >= 200) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done in 200 cycles, required done", name);
      sb.delete();
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL %s_busy: got wrong busy profile, required high for %0d cycles", name, elat - 1);
    end
  endtask

  logic [W-1:0] hi_before;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_flags", {29'd0, busy, done, div_zero}, '0);

    run_op("mult_7_m3_move", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT, 1'b1, 1'b0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT, 1'b0, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT, 1'b0, 1'b0);
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, LAT, 1'b0, 1'b0);
    run_op("divu_by_zero", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, DZ_LAT, 1'b0, 1'b0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, LAT, 1'b0, 1'b0);
    run_op("div_neg_by_zero", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, DZ_LAT, 1'b0, 1'b0);
    run_op("mult_m5_m6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0, LAT, 1'b0, 1'b0);
    run_op("multu_msb_2", OP_MULTU, 32'h8000_0000, 32'd2, 32'h0000_0001, 32'h0000_0000, 1'b0, LAT, 1'b0, 1'b0);

    // Register moves in IDLE.
    @(negedge clk);
    hi_before = hi;
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi_kept", hi, hi_before);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_hi", hi, 32'h5A5A_5A5A);
    chk("mthi_mtlo_lo", lo, 32'h5A5A_5A5A);

    // Second start and mthi pulsed mid-CALC must be ignored.
    run_op("divu_100_7_disturbed", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, LAT, 1'b0, 1'b1);

    // Reset in the middle of a multiply aborts it with HI/LO cleared.
    @(negedge clk);
    op = OP_MULT; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop_reset_hi", hi, '0);
    chk("midop_reset_lo", lo, '0);
    chk("midop_reset_flags", {30'd0, busy, done}, '0);

    run_op("multu_3_5", OP_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0, LAT, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
